// File: rtl/if_id_fetch_ctrl.sv
// if_id_fetch_ctrl: fetch-side pipeline control.
// Owns the PC, the instruction-memory request handshake, a one-entry skid
// buffer for fetches that complete while decode is stalled, and the IF/ID
// pipeline register. Takes stall/flush from the hazard unit and redirects
// from EX.
// Optional build macro FETCH_PERF_EN adds saturating stall/bubble/flush
// counters as extra outputs.
module if_id_fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_ID_Flush,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] IDinstr,
  output logic [15:0] IDpcplus2,
  output logic        IDvalid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] id_instr_q, id_instr_d;
  logic [15:0] id_pcplus2_q, id_pcplus2_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pcplus2_q, buf_pcplus2_d;
  logic        imem_req_q;
  logic        halted_q;

  logic [15:0] pc_plus2;
  logic        fetch_done;

  assign pc_plus2   = pc_q + 16'd2;
  assign fetch_done = imem_req_q & imem_ready;

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign IDinstr   = id_instr_q;
  assign IDpcplus2 = id_pcplus2_q;
  assign IDvalid   = id_valid_q;
  assign halted    = halted_q;

  // Next-state decision: Redirect > Flush > stall > normal advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pcplus2_d  = id_pcplus2_q;
    id_valid_d    = id_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pcplus2_d = buf_pcplus2_q;

    if (Redirect) begin
      // Completing fetch and any buffered word are dropped by returning to FETCH.
      pc_d    = RedirectPC;
      state_d = S_FETCH;
      if (IF_ID_Write) begin
        id_instr_d   = NOP_INSTR;
        id_pcplus2_d = 16'h0000;
        id_valid_d   = 1'b0;
      end
    end else if (IF_ID_Flush) begin
      id_instr_d   = NOP_INSTR;
      id_pcplus2_d = 16'h0000;
      id_valid_d   = 1'b0;
      // A halted front end stays frozen; only Redirect or reset restarts it.
      if (state_q != S_HALT) begin
        state_d = S_FETCH;
        if (PCWrite) begin
          pc_d = pc_plus2;
        end
      end
    end else if (!IF_ID_Write) begin
      // Decode stalled: park a completing fetch in the skid entry.
      if (state_q == S_FETCH && fetch_done) begin
        buf_instr_d   = imem_data;
        buf_pcplus2_d = pc_plus2;
        state_d       = S_BUFFERED;
        if (PCWrite) begin
          pc_d = pc_plus2;
        end
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch_done && PCWrite) begin
            id_instr_d   = imem_data;
            id_pcplus2_d = pc_plus2;
            id_valid_d   = 1'b1;
            pc_d         = pc_plus2;
            if (imem_data[15:11] == 5'b00000) begin
              state_d = S_HALT;
            end
          end else begin
            // Miss, or fetch refused by the hazard unit: insert a bubble.
            id_instr_d   = NOP_INSTR;
            id_pcplus2_d = 16'h0000;
            id_valid_d   = 1'b0;
          end
        end
        S_BUFFERED: begin
          // Drain cycle: no new request goes out this cycle.
          id_instr_d   = buf_instr_q;
          id_pcplus2_d = buf_pcplus2_q;
          id_valid_d   = 1'b1;
          state_d      = (buf_instr_q[15:11] == 5'b00000) ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // FSM, PC, skid buffer and IF/ID register with registered req/halted outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pcplus2_q  <= 16'h0000;
      id_valid_q    <= 1'b0;
      buf_instr_q   <= 16'h0000;
      buf_pcplus2_q <= 16'h0000;
      imem_req_q    <= 1'b1;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pcplus2_q  <= id_pcplus2_d;
      id_valid_q    <= id_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pcplus2_q <= buf_pcplus2_d;
      imem_req_q    <= (state_d == S_FETCH);
      halted_q      <= (state_d == S_HALT);
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble_evt;

  // A bubble is a NOP load from a miss or from PCWrite=0 in the normal path.
  assign bubble_evt = IF_ID_Write & ~Redirect & ~IF_ID_Flush &
                      (state_q == S_FETCH) & ~(fetch_done & PCWrite);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
      flush_cnt  <= 32'd0;
    end else begin
      if (!IF_ID_Write && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bubble_evt && bubble_cnt != 32'hFFFF_FFFF) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if ((IF_ID_Flush || Redirect) && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
